// File: rtl/mips_run_ctrl_pkg.sv
// mips_run_ctrl_pkg
//   Shared definitions for the MIPS run-control block:
//   - 3-bit FSM state encodings (IDLE..STEP) and the matching enum type
//   - default pipeline drain length
//   - lowest_set_idx(): index of the lowest set bit in a breakpoint match vector
package mips_run_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_HALTED = 3'd3;
  localparam logic [2:0] ST_STEP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_RUN    = ST_RUN,
    S_DRAIN  = ST_DRAIN,
    S_HALTED = ST_HALTED,
    S_STEP   = ST_STEP
  } run_state_e;

  // Five-stage pipe: the last fetched instruction needs four more cycles to reach WB.
  localparam int DEFAULT_DRAIN_CYCLES = 4;

  // Upper bound on breakpoint comparators; brk_idx is 3 bits wide.
  localparam int MAX_BRK = 8;

  // Lowest set bit wins so that comparator priority is deterministic.
  function automatic logic [2:0] lowest_set_idx(input logic [MAX_BRK-1:0] v);
    lowest_set_idx = 3'd0;
    for (int i = MAX_BRK - 1; i >= 0; i--) begin
      if (v[i]) lowest_set_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/mips_sat_counter.sv
// mips_sat_counter
//   Saturating up-counter, cleared only by reset.
//   Ports:
//     clk   - clock, rising edge
//     reset - synchronous active-high clear
//     inc   - add one this cycle (ignored once the count is all-ones)
//     count - registered count value
module mips_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Hold at all-ones instead of wrapping so long runs never read back as small values.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl
//   Run-control for the 5-stage MIPS pipeline: start, orderly halt with pipeline
//   drain, single-step and PC breakpoints. Drives the DataPath fetch/advance
//   enables and an optional pair of performance counters.
//
//   Optional feature macro: MIPS_RUN_CTRL_PERF_EN
//     defined   - cycle_cnt / retire_cnt are saturating counters
//     undefined - no counter flops, both outputs tied to 0
//
//   Ports:
//     clk, reset    - clock, synchronous active-high reset
//     start         - level, begin or resume execution
//     halt_req      - level, request orderly halt
//     step_req      - pulse, execute one instruction while HALTED
//     brk_en        - per-comparator enable
//     brk_addr      - packed breakpoint PCs, slot i = [i*PC_W +: PC_W]
//     if_pc         - PC presented to fetch
//     retire_valid  - an instruction writes back this cycle
//     fetch_en      - allow PC update / IF capture (combinational)
//     pipe_en       - advance pipeline registers
//     flush         - one-cycle clear of pipeline registers
//     halted        - high in HALTED
//     state         - current FSM state
//     brk_hit       - last halt caused by a breakpoint (sticky)
//     brk_idx       - lowest matching comparator index
//     cycle_cnt     - cycles with pipe_en high
//     retire_cnt    - retired instructions
module mips_run_ctrl
  import mips_run_ctrl_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int N_BRK        = 2,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  step_req,
  input  logic [N_BRK-1:0]      brk_en,
  input  logic [N_BRK*PC_W-1:0] brk_addr,
  input  logic [PC_W-1:0]       if_pc,
  input  logic                  retire_valid,
  output logic                  fetch_en,
  output logic                  pipe_en,
  output logic                  flush,
  output logic                  halted,
  output logic [2:0]            state,
  output logic                  brk_hit,
  output logic [2:0]            brk_idx,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      retire_cnt
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  run_state_e         state_d, state_q;
  logic [DCW-1:0]     drain_cnt_d, drain_cnt_q;
  logic               pipe_en_d, pipe_en_q;
  logic               flush_d, flush_q;
  logic               halted_d, halted_q;
  logic               brk_hit_d, brk_hit_q;
  logic [2:0]         brk_idx_d, brk_idx_q;
  logic               resume_d, resume_q;
  logic [MAX_BRK-1:0] match_vec;
  logic               brk_match;

  // Comparators are live only in RUN, and not on the first cycle after a
  // resume from HALTED, so execution can step off the PC it stopped at.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < N_BRK; i++) begin
      match_vec[i] = brk_en[i] && (if_pc == brk_addr[i*PC_W +: PC_W]);
    end
    brk_match = (state_q == S_RUN) && !resume_q && (|match_vec);
  end

  // The matching instruction must never be captured, so fetch_en drops in the
  // same cycle the comparator fires rather than a cycle later.
  assign fetch_en = ((state_q == S_RUN) || (state_q == S_STEP)) && !brk_match;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    brk_hit_d   = brk_hit_q;
    brk_idx_d   = brk_idx_q;
    flush_d     = 1'b0;
    resume_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          flush_d   = 1'b1;
          brk_hit_d = 1'b0;
        end
      end

      S_RUN: begin
        // An explicit halt outranks a breakpoint and reports no breakpoint cause.
        if (halt_req) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
          brk_hit_d   = 1'b0;
        end else if (brk_match) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
          brk_hit_d   = 1'b1;
          brk_idx_d   = lowest_set_idx(match_vec);
        end
      end

      S_DRAIN: begin
        if (drain_cnt_q == '0) state_d = S_HALTED;
        else                   drain_cnt_d = drain_cnt_q - 1'b1;
      end

      S_HALTED: begin
        // start takes precedence over step; start with halt_req held does nothing.
        if (start) begin
          if (!halt_req) begin
            state_d   = S_RUN;
            resume_d  = 1'b1;
            brk_hit_d = 1'b0;
          end
        end else if (step_req) begin
          state_d   = S_STEP;
          brk_hit_d = 1'b0;
        end
      end

      S_STEP: begin
        state_d     = S_DRAIN;
        drain_cnt_d = DRAIN_LOAD;
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up
    // with the state register.
    pipe_en_d = (state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_STEP);
    halted_d  = (state_d == S_HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      pipe_en_q   <= 1'b0;
      flush_q     <= 1'b0;
      halted_q    <= 1'b0;
      brk_hit_q   <= 1'b0;
      brk_idx_q   <= 3'd0;
      resume_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      pipe_en_q   <= pipe_en_d;
      flush_q     <= flush_d;
      halted_q    <= halted_d;
      brk_hit_q   <= brk_hit_d;
      brk_idx_q   <= brk_idx_d;
      resume_q    <= resume_d;
    end
  end

  assign pipe_en = pipe_en_q;
  assign flush   = flush_q;
  assign halted  = halted_q;
  assign state   = state_q;
  assign brk_hit = brk_hit_q;
  assign brk_idx = brk_idx_q;

`ifdef MIPS_RUN_CTRL_PERF_EN
  // Retirements only count while the pipe advances, so a stalled WB is not double counted.
  mips_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pipe_en_q),
    .count (cycle_cnt)
  );

  mips_sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (retire_valid && pipe_en_q),
    .count (retire_cnt)
  );
`else
  logic unused_retire_valid;
  assign unused_retire_valid = retire_valid;
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule
